// File: rtl/switch_reader.sv
// Slide-switch / push-button MMIO read port: 2-flop sync, optional per-bit debounce
// (enabled by `SW_DEBOUNCE_EN), sticky button-press flags and a registered read path.
module switch_reader #(
  parameter int SW_WIDTH        = 16,
  parameter int BTN_WIDTH       = 5,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                 sw_clk,
  input  logic                 swrst,
  input  logic                 swread,
  input  logic [1:0]           swaddr,
  input  logic [SW_WIDTH-1:0]  sw_in,
  input  logic [BTN_WIDTH-1:0] btn_in,
  output logic [15:0]          swrdata,
  output logic                 swrvalid,
  output logic                 btn_event
);

  localparam int N = SW_WIDTH + BTN_WIDTH;

  logic [N-1:0]         meta;
  logic [N-1:0]         sync;
  logic [N-1:0]         stable;
  logic [SW_WIDTH-1:0]  sw_stable;
  logic [BTN_WIDTH-1:0] btn_stable;
  logic [BTN_WIDTH-1:0] btn_prev;
  logic [BTN_WIDTH-1:0] flags;
  logic [BTN_WIDTH-1:0] rise;
  logic [BTN_WIDTH-1:0] flag_next;
  logic                 rd_clear;
  logic [15:0]          rd_mux;

  always_ff @(posedge sw_clk) begin
    if (swrst) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= {btn_in, sw_in};
      sync <= meta;
    end
  end

`ifdef SW_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt [N];

  // Counter runs only while sync disagrees with stable; any agreement restarts it.
  always_ff @(posedge sw_clk) begin
    if (swrst) begin
      stable <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (sync[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == TERM) begin
          stable[i] <= sync[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  always_ff @(posedge sw_clk) begin
    if (swrst) stable <= '0;
    else       stable <= sync;
  end
`endif

  assign sw_stable  = stable[SW_WIDTH-1:0];
  assign btn_stable = stable[N-1:SW_WIDTH];

  // A rise in the clearing cycle is OR-ed in after the clear, so set wins.
  always_comb begin
    rise      = btn_stable & ~btn_prev;
    rd_clear  = swread && (swaddr == 2'b10);
    flag_next = (rd_clear ? '0 : flags) | rise;
  end

  always_comb begin
    rd_mux = '0;
    case (swaddr)
      2'b00:   rd_mux[SW_WIDTH-1:0]  = sw_stable;
      2'b01:   rd_mux[BTN_WIDTH-1:0] = btn_stable;
      2'b10:   rd_mux[BTN_WIDTH-1:0] = flags;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge sw_clk) begin
    if (swrst) begin
      btn_prev  <= '0;
      flags     <= '0;
      btn_event <= 1'b0;
      swrdata   <= '0;
      swrvalid  <= 1'b0;
    end else begin
      btn_prev  <= btn_stable;
      flags     <= flag_next;
      btn_event <= |flag_next;
      swrvalid  <= swread;
      if (swread) swrdata <= rd_mux;
    end
  end

endmodule
